// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: programmable H/V state machines with shadowed timing sets swapped in at frame end.
// Latency: a pixel accepted in cycle n drives r/g/b together with de/hsync/vsync in cycle n+1.
// Backpressure: pix_ready is a pull strobe with no buffering; a missing pixel outputs black and sets underflow.
module vga_timing_ctrl #(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [10:0] cfg_act,
    input  logic [7:0]  cfg_fp,
    input  logic [7:0]  cfg_sync,
    input  logic [7:0]  cfg_bp,
    output logic        cfg_pending,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    typedef struct packed {
        logic [10:0] act;
        logic [7:0]  fp;
        logic [7:0]  sync;
        logic [7:0]  bp;
    } tset_t;

    typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} h_state_t;
    typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} v_state_t;

    // Zero widths become 1 so every state lasts at least one cycle/line.
    function automatic tset_t clamp_set(input logic [10:0] act, input logic [7:0] fp,
                                        input logic [7:0] sync, input logic [7:0] bp);
        tset_t t;
        t.act  = (act  == 11'd0) ? 11'd1 : act;
        t.fp   = (fp   == 8'd0)  ? 8'd1  : fp;
        t.sync = (sync == 8'd0)  ? 8'd1  : sync;
        t.bp   = (bp   == 8'd0)  ? 8'd1  : bp;
        return t;
    endfunction

    localparam tset_t H_RST = clamp_set(11'(HOR_ACT), 8'(HOR_FP), 8'(HOR_SYNC), 8'(HOR_BP));
    localparam tset_t V_RST = clamp_set(11'(VERT_ACT), 8'(VERT_FP), 8'(VERT_SYNC), 8'(VERT_BP));

    tset_t       h_cur, v_cur, h_shd, v_shd, cfg_set;
    h_state_t    h_state, h_state_nxt;
    v_state_t    v_state, v_state_nxt;
    logic [10:0] pix_cnt, pix_cnt_nxt;
    logic [10:0] line_cnt, line_cnt_nxt;
    logic [10:0] h_width, v_width;
    logic        h_last, v_last, line_end, frame_end;

    assign cfg_set = clamp_set(cfg_act, cfg_fp, cfg_sync, cfg_bp);

    always_comb begin
        h_width = {3'b000, h_cur.sync};
        case (h_state)
            H_SYNC: h_width = {3'b000, h_cur.sync};
            H_BP:   h_width = {3'b000, h_cur.bp};
            H_ACT:  h_width = h_cur.act;
            H_FP:   h_width = {3'b000, h_cur.fp};
        endcase
    end

    always_comb begin
        v_width = {3'b000, v_cur.sync};
        case (v_state)
            V_SYNC: v_width = {3'b000, v_cur.sync};
            V_BP:   v_width = {3'b000, v_cur.bp};
            V_ACT:  v_width = v_cur.act;
            V_FP:   v_width = {3'b000, v_cur.fp};
        endcase
    end

    assign h_last    = (pix_cnt == h_width - 11'd1);
    assign v_last    = (line_cnt == v_width - 11'd1);
    assign line_end  = (h_state == H_FP) && h_last;
    assign frame_end = enable && line_end && (v_state == V_FP) && v_last;

    assign pix_ready = enable && !rst && (h_state == H_ACT) && (v_state == V_ACT);

    always_comb begin
        h_state_nxt  = h_state;
        v_state_nxt  = v_state;
        pix_cnt_nxt  = pix_cnt;
        line_cnt_nxt = line_cnt;
        if (!enable) begin
            h_state_nxt  = H_SYNC;
            v_state_nxt  = V_SYNC;
            pix_cnt_nxt  = 11'd0;
            line_cnt_nxt = 11'd0;
        end else begin
            if (h_last) begin
                pix_cnt_nxt = 11'd0;
                case (h_state)
                    H_SYNC: h_state_nxt = H_BP;
                    H_BP:   h_state_nxt = H_ACT;
                    H_ACT:  h_state_nxt = H_FP;
                    H_FP:   h_state_nxt = H_SYNC;
                endcase
            end else begin
                pix_cnt_nxt = pix_cnt + 11'd1;
            end
            // The vertical machine steps once per line, on the final front-porch pixel.
            if (line_end) begin
                if (v_last) begin
                    line_cnt_nxt = 11'd0;
                    case (v_state)
                        V_SYNC: v_state_nxt = V_BP;
                        V_BP:   v_state_nxt = V_ACT;
                        V_ACT:  v_state_nxt = V_FP;
                        V_FP:   v_state_nxt = V_SYNC;
                    endcase
                end else begin
                    line_cnt_nxt = line_cnt + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_state  <= H_SYNC;
            v_state  <= V_SYNC;
            pix_cnt  <= 11'd0;
            line_cnt <= 11'd0;
        end else begin
            h_state  <= h_state_nxt;
            v_state  <= v_state_nxt;
            pix_cnt  <= pix_cnt_nxt;
            line_cnt <= line_cnt_nxt;
        end
    end

    // A write landing on the apply cycle stays in the shadow for the following frame.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cur       <= H_RST;
            v_cur       <= V_RST;
            h_shd       <= H_RST;
            v_shd       <= V_RST;
            cfg_pending <= 1'b0;
        end else begin
            if (frame_end) begin
                h_cur       <= h_shd;
                v_cur       <= v_shd;
                cfg_pending <= 1'b0;
            end
            if (cfg_we) begin
                if (cfg_sel) v_shd <= cfg_set;
                else         h_shd <= cfg_set;
                cfg_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= !(enable && (h_state == H_SYNC));
            vsync       <= !(enable && (v_state == V_SYNC));
            de          <= pix_ready;
            {r, g, b}   <= (pix_ready && pix_valid) ? pix_rgb : 24'd0;
            frame_start <= enable && (h_state == H_SYNC) && (v_state == V_SYNC)
                           && (pix_cnt == 11'd0) && (line_cnt == 11'd0);
            if (pix_ready && !pix_valid) underflow <= 1'b1;
            else if (underflow_clr)      underflow <= 1'b0;
        end
    end

endmodule
